vga_frame_sequencer: RTL and testbench

VGA_FRAME_SEQUENCER -- requirements
Module: vga_frame_sequencer

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_frame_sequencer_rise_detect.sv | 19 +
 rtl/vga_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_vga_frame_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and the frame-sequencer state encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT    = 640;
  localparam int V_ACTIVE_DEFAULT    = 480;
  localparam int BLOCK_SIZE_DEFAULT  = 32;
  localparam int STEP_FRAMES_DEFAULT = 32;

  localparam int COORD_W = 11;
  localparam int STEPS_W = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } seq_state_t;

endpackage

// File: rtl/vga_frame_sequencer_rise_detect.sv
// Rising-edge detector: pulse is high while in is 1 and was 0 one cycle ago.
module rise_detect (
  input  logic clk_25MHz,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Registered copy of the input, cleared by reset.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) in_q <= 1'b0;
    else          in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/vga_frame_sequencer.sv
// Frame-synchronous mode latch and block-move animator.
// Handshake: none; move is a level whose 0->1 transition requests one
// animation of STEP_FRAMES steps, one step per frame_tick. A request made
// while animating is held in a single pending slot; extra requests are dropped.
module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE    = V_ACTIVE_DEFAULT,
  parameter int BLOCK_SIZE  = BLOCK_SIZE_DEFAULT,
  parameter int STEP_FRAMES = STEP_FRAMES_DEFAULT
) (
  input  logic        clk_25MHz,
  input  logic        reset_n,
  input  logic [1:0]  select,
  input  logic        move,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic [1:0]  mode,
  output logic [10:0] block_x,
  output logic [10:0] block_y,
  output logic        busy,
  output logic        frame_tick
);

  localparam logic [10:0]  X_LAST     = 11'(H_ACTIVE - BLOCK_SIZE);
  localparam logic [10:0]  Y_LAST     = 11'(V_ACTIVE - BLOCK_SIZE);
  localparam logic [10:0]  V_BLANK    = 11'(V_ACTIVE);
  localparam logic [10:0]  BLK        = 11'(BLOCK_SIZE);
  localparam logic [STEPS_W-1:0] STEPS_INIT = STEPS_W'(STEP_FRAMES);

  seq_state_t          state, state_next;
  logic [STEPS_W-1:0]  steps_left, steps_next;
  logic                pending, pending_next;
  logic [10:0]         x_next, y_next;
  logic [10:0]         x_step, y_step;
  logic                move_rise;

  rise_detect u_rise (
    .clk_25MHz (clk_25MHz),
    .reset_n   (reset_n),
    .in        (move),
    .pulse     (move_rise)
  );

  assign busy = (state == MOVING);

  // Frame boundary pulse one cycle after the first pixel of vertical blank.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) frame_tick <= 1'b0;
    else          frame_tick <= (hcount == 11'd0) && (vcount == V_BLANK);
  end

  // Mode only follows the switches at frame boundaries to avoid tearing.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n)        mode <= 2'd0;
    else if (frame_tick) mode <= select;
  end

  // Position of the block after one step, wrapping right edge then bottom edge.
  always_comb begin
    x_step = block_x + 11'd1;
    y_step = block_y;
    if (block_x == X_LAST) begin
      x_step = 11'd0;
      y_step = (block_y == Y_LAST) ? 11'd0 : block_y + BLK;
    end
  end

  // Animation FSM: next state, step counter, pending slot and position.
  always_comb begin
    state_next   = state;
    steps_next   = steps_left;
    pending_next = pending;
    x_next       = block_x;
    y_next       = block_y;
    case (state)
      IDLE: begin
        // A rise coincident with a tick starts the animation without stepping.
        if (move_rise) begin
          state_next   = MOVING;
          steps_next   = STEPS_INIT;
          pending_next = 1'b0;
        end
      end
      MOVING: begin
        if (frame_tick) begin
          x_next     = x_step;
          y_next     = y_step;
          steps_next = steps_left - 1'b1;
          if (steps_left == 1) begin
            if (pending || move_rise) begin
              steps_next   = STEPS_INIT;
              pending_next = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else if (move_rise) begin
            pending_next = 1'b1;
          end
        end else if (move_rise) begin
          pending_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      steps_left <= '0;
      pending    <= 1'b0;
      block_x    <= 11'd0;
      block_y    <= 11'd0;
    end else begin
      state      <= state_next;
      steps_left <= steps_next;
      pending    <= pending_next;
      block_x    <= x_next;
      block_y    <= y_next;
    end
  end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer with default geometry.
module tb_vga_frame_sequencer;
  import vga_pkg::*;

  localparam int V_ACT = V_ACTIVE_DEFAULT;

  logic        clk_25MHz = 1'b0;
  logic        reset_n   = 1'b0;
  logic [1:0]  select    = 2'd0;
  logic        move      = 1'b0;
  logic [10:0] hcount    = 11'd1;
  logic [10:0] vcount    = 11'd0;
  logic [1:0]  mode;
  logic [10:0] block_x;
  logic [10:0] block_y;
  logic        busy;
  logic        frame_tick;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];
  int ex, ey;

  vga_frame_sequencer dut (
    .clk_25MHz  (clk_25MHz),
    .reset_n    (reset_n),
    .select     (select),
    .move       (move),
    .hcount     (hcount),
    .vcount     (vcount),
    .mode       (mode),
    .block_x    (block_x),
    .block_y    (block_y),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  // Clock / reset
  always #20 clk_25MHz = ~clk_25MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int b);
    check({tag, ".x"}, 32'(block_x), 32'(x));
    check({tag, ".y"}, 32'(block_y), 32'(y));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic apply_reset();
    @(negedge clk_25MHz) reset_n = 1'b0;
    repeat (2) @(negedge clk_25MHz);
    reset_n = 1'b1;
    @(negedge clk_25MHz);
  endtask

  // Drivers
  task automatic tick();
    @(negedge clk_25MHz) begin hcount = 11'd0; vcount = 11'(V_ACT); end
    @(negedge clk_25MHz) begin hcount = 11'd1; vcount = 11'd0; end
    @(negedge clk_25MHz);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic tick_with_move();
    @(negedge clk_25MHz) begin hcount = 11'd0; vcount = 11'(V_ACT); end
    @(negedge clk_25MHz) begin hcount = 11'd1; vcount = 11'd0; move = 1'b1; end
    @(negedge clk_25MHz) move = 1'b0;
    @(negedge clk_25MHz);
  endtask

  task automatic move_rise();
    @(negedge clk_25MHz) move = 1'b1;
    @(negedge clk_25MHz) move = 1'b0;
  endtask

  // Reference block step: right-edge wrap, then bottom-edge wrap.
  task automatic model_step();
    if (ex == 608) begin
      ex = 0;
      ey = (ey == 448) ? 0 : ey + 32;
    end else begin
      ex = ex + 1;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_25MHz);
    check("rst.mode", 32'(mode), 32'd0);
    check_pos("rst", 0, 0, 0);
    check("rst.tick", 32'(frame_tick), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_25MHz);

    // Single animation
    move_rise();
    check("anim.busy_next", 32'(busy), 32'd1);
    check("anim.steps_init", 32'(dut.steps_left), 32'd32);
    ticks(31);
    check_pos("anim.31", 31, 0, 1);
    tick();
    check_pos("anim.32", 32, 0, 0);
    check("anim.steps_end", 32'(dut.steps_left), 32'd0);
    tick();
    check_pos("anim.idle_tick", 32, 0, 0);

    // Frame tick decode and mode latching
    @(negedge clk_25MHz) begin hcount = 11'd0; vcount = 11'(V_ACT - 1); end
    @(negedge clk_25MHz) begin hcount = 11'd1; vcount = 11'(V_ACT); end
    check("tick.wrong_row", 32'(frame_tick), 32'd0);
    @(negedge clk_25MHz) select = 2'd2;
    check("tick.wrong_col", 32'(frame_tick), 32'd0);
    repeat (3) @(negedge clk_25MHz);
    check("mode.hold", 32'(mode), 32'd0);
    hcount = 11'd0; vcount = 11'(V_ACT);
    @(negedge clk_25MHz) begin hcount = 11'd1; vcount = 11'd0; end
    check("tick.high", 32'(frame_tick), 32'd1);
    check("mode.before_load", 32'(mode), 32'd0);
    @(negedge clk_25MHz);
    check("tick.one_cycle", 32'(frame_tick), 32'd0);
    check("mode.loaded", 32'(mode), 32'd2);
    select = 2'd0;

    // Pending request, extra request dropped
    apply_reset();
    check_pos("pend.rst", 0, 0, 0);
    move_rise();
    ticks(5);
    move_rise();
    move_rise();
    ticks(27);
    check_pos("pend.32", 32, 0, 1);
    check("pend.reload", 32'(dut.steps_left), 32'd32);
    ticks(32);
    check_pos("pend.64", 64, 0, 0);
    tick();
    check_pos("pend.after", 64, 0, 0);

    // Reset mid-animation
    move_rise();
    ticks(10);
    check_pos("rstmid.10", 74, 0, 1);
    @(negedge clk_25MHz) reset_n = 1'b0;
    #5;
    check_pos("rstmid.now", 0, 0, 0);
    check("rstmid.mode", 32'(mode), 32'd0);
    check("rstmid.steps", 32'(dut.steps_left), 32'd0);
    @(negedge clk_25MHz) reset_n = 1'b1;
    ticks(4);
    check_pos("rstmid.no_motion", 0, 0, 0);

    // Rise coincident with a tick in IDLE, then with the final tick
    tick_with_move();
    check_pos("coinc.idle", 0, 0, 1);
    check("coinc.idle_steps", 32'(dut.steps_left), 32'd32);
    ticks(31);
    check("coinc.steps1", 32'(dut.steps_left), 32'd1);
    tick_with_move();
    check_pos("coinc.final", 32, 0, 1);
    check("coinc.final_steps", 32'(dut.steps_left), 32'd32);
    ticks(32);
    check_pos("coinc.done", 64, 0, 0);

    // Horizontal wrap at the right edge
    apply_reset();
    repeat (19) begin
      move_rise();
      ticks(32);
    end
    check_pos("hwrap.608", 608, 0, 0);
    move_rise();
    tick();
    check_pos("hwrap.next_row", 0, 32, 1);
    ticks(31);
    check_pos("hwrap.31", 31, 32, 0);

    // Long run through the vertical wrap, scoreboarded per animation
    ex = 31; ey = 32;
    repeat (266) begin
      move_rise();
      repeat (32) begin
        tick();
        model_step();
      end
      exp_q.push_back({10'd0, 11'(ey), 11'(ex)});
      check("vwrap.anim", {10'd0, block_y, block_x}, exp_q.pop_front());
    end
    check_pos("vwrap.final", 17, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
